// File: rtl/fifo_word_packer.sv
// Packs IN_W-bit symbols popped from the symbol FIFO into OUT_W-bit words with a frame-end marker.
// Define FIFO_PACKER_MSB_FIRST_EN to place the first symbol of each word in the MSBs (default: LSBs).
module fifo_word_packer #(
    parameter int IN_W            = 3,
    parameter int SYMS_PER_WORD   = 4,
    parameter int WORDS_PER_FRAME = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [IN_W-1:0]               fifo_data,
    output logic                          fifo_r_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IN_W*SYMS_PER_WORD-1:0] out_data,
    output logic                          out_last
);
    localparam int OUT_W = IN_W * SYMS_PER_WORD;
    localparam int CW    = $clog2(SYMS_PER_WORD + 1);
    localparam int WW    = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(SYMS_PER_WORD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SYMS_PER_WORD - 1);
    localparam logic [CW:0]   FILL_FULL = (CW+1)'(SYMS_PER_WORD);
    localparam logic [WW-1:0] WCNT_LAST = WW'(WORDS_PER_FRAME - 1);

    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             pend_r;
    logic [OUT_W-1:0] acc_r, acc_nxt_s;
    logic [WW-1:0]    wcnt_r, wcnt_nxt_s;
    logic [CW:0]      fill_s;
    logic             out_free_s;
    logic             hs_s;
    logic             load_s;
    logic [OUT_W-1:0] load_word_s;
    logic             load_last_s;

    function automatic logic [OUT_W-1:0] put_slot(input logic [OUT_W-1:0] word,
                                                  input logic [CW-1:0]    idx,
                                                  input logic [IN_W-1:0]  sym);
        logic [OUT_W-1:0] res;
        res = word;
        for (int k = 0; k < SYMS_PER_WORD; k++) begin
            if (idx == CW'(k)) begin
`ifdef FIFO_PACKER_MSB_FIRST_EN
                res[(SYMS_PER_WORD-1-k)*IN_W +: IN_W] = sym;
`else
                res[k*IN_W +: IN_W] = sym;
`endif
            end
        end
        return res;
    endfunction

    // Pop request: keep cnt+pend within one word, or overlap when the completing word can leave now.
    always_comb begin
        out_free_s = !out_valid || out_ready;
        fill_s     = {1'b0, cnt_r} + {{CW{1'b0}}, pend_r};
        fifo_r_en  = 1'b0;
        if (!rst && !fifo_empty) begin
            if (fill_s < FILL_FULL) begin
                fifo_r_en = 1'b1;
            end else if (pend_r && (cnt_r == CNT_LAST) && out_free_s) begin
                fifo_r_en = 1'b1;
            end else begin
                fifo_r_en = 1'b0;
            end
        end else begin
            fifo_r_en = 1'b0;
        end
    end

    // Accumulator fill, word completion and release of a held word.
    always_comb begin
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        load_word_s = acc_r;
        if (pend_r) begin
            acc_nxt_s = put_slot(acc_r, cnt_r, fifo_data);
            if (cnt_r == CNT_LAST) begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_word_s = acc_nxt_s;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    cnt_nxt_s = CNT_FULL;
                end
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else if ((cnt_r == CNT_FULL) && out_free_s) begin
            load_s      = 1'b1;
            load_word_s = acc_r;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Frame position; a word loaded during a handshake takes the position after the departing one.
    always_comb begin
        hs_s       = out_valid && out_ready;
        wcnt_nxt_s = wcnt_r;
        if (hs_s) begin
            if (wcnt_r == WCNT_LAST) begin
                wcnt_nxt_s = {WW{1'b0}};
            end else begin
                wcnt_nxt_s = wcnt_r + WW'(1);
            end
        end else begin
            wcnt_nxt_s = wcnt_r;
        end
        load_last_s = (wcnt_nxt_s == WCNT_LAST);
    end

    // Packing state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            pend_r <= 1'b0;
            acc_r  <= {OUT_W{1'b0}};
            wcnt_r <= {WW{1'b0}};
        end else begin
            cnt_r  <= cnt_nxt_s;
            pend_r <= fifo_r_en;
            acc_r  <= acc_nxt_s;
            wcnt_r <= wcnt_nxt_s;
        end
    end

    // Output register: loads a finished word, clears valid after a handshake, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {OUT_W{1'b0}};
            out_last  <= 1'b0;
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_data  <= load_word_s;
            out_last  <= load_last_s;
        end else if (hs_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: vector table, directed corner sequences and a random run
// scored against a FIFO/packing reference model.
module tb_fifo_word_packer;
    localparam int IN_W  = 3;
    localparam int S     = 4;
    localparam int W     = 6;
    localparam int OUT_W = IN_W * S;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_data;
    logic             fifo_r_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    fifo_word_packer #(.IN_W(IN_W), .SYMS_PER_WORD(S), .WORDS_PER_FRAME(W)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IN_W-1:0]  s0, s1, s2, s3;
        logic [OUT_W-1:0] exp_lsb, exp_msb;
        logic             exp_last;
    } vec_t;
    vec_t tbl [6];

    int n_vec = 0, n_err = 0;
    int hs_cnt = 0, pop_cnt = 0, frame_idx = 0, valid_seen = 0;
    int run_len = 0, max_run = 0, cyc = 0;
    logic [OUT_W-1:0] hs_data;
    logic             hs_last;
    logic             stall_v = 1'b0;
    logic [OUT_W-1:0] stall_d;
    logic             stall_l;
    logic [IN_W-1:0]  fq[$];
    logic [IN_W-1:0]  sbuf[$];
    logic [OUT_W-1:0] exp_q[$];
    int               hs_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: every S popped symbols form one word, first symbol in slot 0.
    task automatic model_sym(input logic [IN_W-1:0] s);
        logic [OUT_W-1:0] w;
        sbuf.push_back(s);
        if (sbuf.size() == S) begin
            w = '0;
            for (int k = 0; k < S; k++) begin
`ifdef FIFO_PACKER_MSB_FIRST_EN
                w = w | (OUT_W'(sbuf[k]) << ((S - 1 - k) * IN_W));
`else
                w = w | (OUT_W'(sbuf[k]) << (k * IN_W));
`endif
            end
            exp_q.push_back(w);
            sbuf.delete();
        end
    endtask

    task automatic cycle();
        logic            pop;
        logic [IN_W-1:0] s;
        s = '0;
        fifo_empty = (fq.size() == 0);
        #1;
        if (fifo_empty) chk("ren_while_empty", 32'(fifo_r_en), 32'(0));
        if (stall_v) begin
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_data", 32'(out_data), 32'(stall_d));
            chk("stall_last", 32'(out_last), 32'(stall_l));
        end
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) chk("word_data", 32'(out_data), 32'(exp_q.pop_front()));
            chk("word_last", 32'(out_last), 32'((frame_idx % W) == (W - 1)));
            frame_idx++;
            hs_cnt++;
            hs_data = out_data;
            hs_last = out_last;
            hs_cyc.push_back(cyc);
        end
        stall_v = out_valid && !out_ready;
        stall_d = out_data;
        stall_l = out_last;
        pop = fifo_r_en;
        if (pop) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            pop_cnt++;
            if (fq.size() != 0) s = fq.pop_front();
            model_sym(s);
        end else begin
            run_len = 0;
        end
        @(posedge clk);
        #1;
        fifo_data = pop ? s : IN_W'($urandom);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_hs(input int n, input int budget, input string nm);
        int start;
        start = hs_cnt;
        for (int i = 0; i < budget && (hs_cnt - start) < n; i++) cycle();
        chk(nm, 32'(hs_cnt - start), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fq.delete();
        sbuf.delete();
        exp_q.delete();
        frame_idx = 0;
        stall_v = 1'b0;
        run_len = 0;
        fifo_empty = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_ren", 32'(fifo_r_en), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pad;
        tbl[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 12'h8D1, 12'h29C, 1'b0};
        tbl[1] = '{3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 12'h000, 1'b0};
        tbl[2] = '{3'd7, 3'd7, 3'd7, 3'd7, 12'hFFF, 12'hFFF, 1'b0};
        tbl[3] = '{3'd7, 3'd0, 3'd0, 3'd0, 12'h007, 12'hE00, 1'b0};
        tbl[4] = '{3'd0, 3'd0, 3'd0, 3'd7, 12'hE00, 12'h007, 1'b0};
        tbl[5] = '{3'd5, 3'd2, 3'd6, 3'd1, 12'h395, 12'hAB1, 1'b1};

        rst = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("init_valid", 32'(out_valid), 32'(0));
        chk("init_data", 32'(out_data), 32'(0));
        chk("init_last", 32'(out_last), 32'(0));
        chk("init_ren", 32'(fifo_r_en), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Vector table: one frame of known words, last flag on the sixth.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fq.push_back(tbl[i].s0); fq.push_back(tbl[i].s1);
            fq.push_back(tbl[i].s2); fq.push_back(tbl[i].s3);
            run_until_hs(1, 30, "tbl_timeout");
`ifdef FIFO_PACKER_MSB_FIRST_EN
            chk("tbl_data", 32'(hs_data), 32'(tbl[i].exp_msb));
`else
            chk("tbl_data", 32'(hs_data), 32'(tbl[i].exp_lsb));
`endif
            chk("tbl_last", 32'(hs_last), 32'(tbl[i].exp_last));
        end

        // Streaming: 24 preloaded symbols, continuous pops, one word every S cycles.
        max_run = 0;
        hs_cyc.delete();
        for (int i = 0; i < 24; i++) fq.push_back(IN_W'($urandom));
        run_until_hs(6, 60, "stream_timeout");
        chk("stream_ren_run", 32'(max_run), 32'(24));
        for (int i = 1; i < hs_cyc.size(); i++) chk("stream_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(S));
        chk("stream_last6", 32'(hs_last), 32'(1));
        for (int i = 0; i < 4; i++) fq.push_back(IN_W'($urandom));
        run_until_hs(1, 30, "next_frame_timeout");
        chk("next_frame_last", 32'(hs_last), 32'(0));

        // Backpressure: 12 symbols available, only 8 may be popped.
        out_ready = 1'b0;
        pop_cnt = 0;
        for (int i = 0; i < 12; i++) fq.push_back(IN_W'($urandom));
        for (int i = 0; i < 20; i++) cycle();
        chk("bp_pops", 32'(pop_cnt), 32'(8));
        chk("bp_valid", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        run_until_hs(3, 40, "bp_release_timeout");

        // Underflow: two symbols, a gap, then two more.
        valid_seen = 0;
        fq.push_back(3'd1); fq.push_back(3'd2);
        for (int i = 0; i < 12; i++) cycle();
        chk("uf_no_valid", 32'(valid_seen), 32'(0));
        fq.push_back(3'd3); fq.push_back(3'd4);
        run_until_hs(1, 20, "uf_timeout");
`ifdef FIFO_PACKER_MSB_FIRST_EN
        chk("uf_data", 32'(hs_data), 32'(12'h29C));
`else
        chk("uf_data", 32'(hs_data), 32'(12'h8D1));
`endif

        // Random traffic and backpressure against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 12) fq.push_back(IN_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        pad = (S - ((sbuf.size() + fq.size()) % S)) % S;
        for (int i = 0; i < pad; i++) fq.push_back(IN_W'($urandom));
        for (int i = 0; i < 200 && (exp_q.size() + fq.size() + sbuf.size()) != 0; i++) cycle();
        chk("rand_drain", 32'(exp_q.size() + fq.size() + sbuf.size()), 32'(0));

        // Reset mid-word, then a fresh frame.
        fq.push_back(3'd6); fq.push_back(3'd5); fq.push_back(3'd4);
        for (int i = 0; i < 8; i++) cycle();
        do_reset();
        for (int i = 0; i < 24; i++) fq.push_back(IN_W'($urandom));
        run_until_hs(6, 80, "post_rst_timeout");
        chk("post_rst_last6", 32'(hs_last), 32'(1));

        // Empty guard.
        valid_seen = 0;
        for (int i = 0; i < 100; i++) cycle();
        chk("empty_no_valid", 32'(valid_seen), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
